// File: rtl/llsc_monitor.sv
// LL/SC reservation monitor: per-channel LLbit, granule address and expiry.
// Decides SC success and clears reservations hit by other channels' stores/SCs.
module llsc_monitor #(
  parameter int NUM_CH   = 1,
  parameter int ADDR_W   = 32,
  parameter int GRAN_LSB = 2,
  parameter int TIMEOUT  = 0,
  parameter int TO_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        flush,
  input  logic [NUM_CH-1:0]        ll_valid,
  input  logic [NUM_CH*ADDR_W-1:0] ll_addr,
  input  logic [NUM_CH-1:0]        sc_valid,
  input  logic [NUM_CH*ADDR_W-1:0] sc_addr,
  input  logic [NUM_CH-1:0]        st_valid,
  input  logic [NUM_CH*ADDR_W-1:0] st_addr,
  output logic [NUM_CH-1:0]        sc_ok,
  output logic [NUM_CH-1:0]        llbit_o
);

  localparam int GW = ADDR_W - GRAN_LSB;

  typedef logic [GW-1:0] gran_t;

  gran_t ll_g   [NUM_CH];
  gran_t sc_g   [NUM_CH];
  gran_t st_g   [NUM_CH];
  gran_t resv_g [NUM_CH];

  logic [NUM_CH-1:0] llbit;
  logic [NUM_CH-1:0] sc_base;
  logic [NUM_CH-1:0] sc_blk;
  logic [NUM_CH-1:0] ok_v;
  logic [NUM_CH-1:0] kill;
  logic [NUM_CH-1:0] expire;

  // Byte-offset bits below the granule never take part in matching.
  logic unused_lo;
  assign unused_lo = ^{ll_addr, sc_addr, st_addr};

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sc_base[c] = ~rst & sc_valid[c] & llbit[c]
                 & (sc_g[c] == resv_g[c])
                 & ~ll_valid[c] & ~flush[c];
    end
  end

  // Same-cycle foreign stores order first; lowest index wins a granule.
  always_comb begin
    ok_v   = '0;
    sc_blk = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k != c && st_valid[k] && st_g[k] == sc_g[c])
          sc_blk[c] = 1'b1;
        if (k < c && ok_v[k] && sc_g[k] == sc_g[c])
          sc_blk[c] = 1'b1;
      end
      ok_v[c] = sc_base[c] & ~sc_blk[c];
    end
  end

  always_comb begin
    kill = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (k != c) begin
          if (st_valid[k] && st_g[k] == resv_g[c])
            kill[c] = 1'b1;
          if (ok_v[k] && sc_g[k] == resv_g[c])
            kill[c] = 1'b1;
        end
      end
    end
  end

  assign sc_ok   = ok_v;
  assign llbit_o = llbit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam int BASE = c * ADDR_W + GRAN_LSB;

    assign ll_g[c] = ll_addr[BASE +: GW];
    assign sc_g[c] = sc_addr[BASE +: GW];
    assign st_g[c] = st_addr[BASE +: GW];

    if (TIMEOUT > 0) begin : g_to
      localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);
      logic [TO_W-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt <= '0;
        else if (ll_valid[c])
          cnt <= '0;
        else if (llbit[c] && cnt != '1)
          cnt <= cnt + TO_W'(1);
      end

      assign expire[c] = llbit[c] & (cnt == LAST);
    end else begin : g_noto
      assign expire[c] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        llbit[c]  <= 1'b0;
        resv_g[c] <= '0;
      end else if (flush[c]) begin
        llbit[c]  <= 1'b0;
      end else if (ll_valid[c]) begin
        llbit[c]  <= 1'b1;
        resv_g[c] <= ll_g[c];
      end else if (sc_valid[c]) begin
        llbit[c]  <= 1'b0;
      end else if (kill[c]) begin
        llbit[c]  <= 1'b0;
      end else if (expire[c]) begin
        llbit[c]  <= 1'b0;
      end
    end
  end

endmodule
